// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared constants, FSM state type and sensor weight helper for the
// infra-red line tracker (ir_line_tracker and its ir_debounce front end).
// ---------------------------------------------------------------------------
package ir_pkg;

    localparam int SENSOR_COUNT = 8;

    // Signed centroid range is -7..+7.
    localparam int POS_W = 5;

    // Weighted sum range is -16..+16 (four outer sensors on one side).
    localparam int SUM_W = 6;

    // Active-sensor count range is 0..8.
    localparam int CNT_W = 4;

    // Quotient never exceeds 7 (single outer sensor).
    localparam int QUO_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } ir_state_e;

    // Sensor i carries weight 2*i - 7: -7, -5, -3, -1, +1, +3, +5, +7.
    function automatic logic signed [SUM_W-1:0] sensor_weight(input logic [2:0] idx);
        int w;
        w = 2 * int'(idx) - SENSOR_COUNT + 1;
        return w[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// ---------------------------------------------------------------------------
// ir_debounce
// Run-length filter on incoming sensor frames. A frame is committed on every
// strobe after which it has been seen FILTER_DEPTH times in a row.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   bits_i    in   raw sensor frame
//   valid_i   in   one-cycle strobe qualifying bits_i
//   commit_o  out  combinational commit strobe, high in the strobe cycle
//   frame_o   out  frame being committed (valid while commit_o is high)
// ---------------------------------------------------------------------------
module ir_debounce
    import ir_pkg::*;
#(
    parameter int FILTER_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SENSOR_COUNT-1:0] bits_i,
    input  logic                    valid_i,
    output logic                    commit_o,
    output logic [SENSOR_COUNT-1:0] frame_o
);

    localparam logic [3:0] DEPTH = 4'(FILTER_DEPTH);

    logic [SENSOR_COUNT-1:0] last_raw_q;
    logic [3:0]              run_cnt_q;
    logic [3:0]              run_cnt_d;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (valid_i) begin
            if (bits_i == last_raw_q) begin
                run_cnt_d = (run_cnt_q >= DEPTH) ? DEPTH : run_cnt_q + 4'd1;
            end else begin
                run_cnt_d = 4'd1;
            end
        end
    end

    // Commit is decided from the post-strobe run length, so a saturated run
    // commits again on every further identical strobe.
    assign commit_o = valid_i && (run_cnt_d == DEPTH);

    // On a commit the new last_raw value always equals the incoming frame.
    assign frame_o  = bits_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_raw_q <= '0;
            run_cnt_q  <= '0;
        end else if (valid_i) begin
            last_raw_q <= bits_i;
            run_cnt_q  <= run_cnt_d;
        end
    end

endmodule

// File: rtl/ir_line_tracker.sv
// ---------------------------------------------------------------------------
// ir_line_tracker
// Turns debounced 8-bit IR sensor frames into a signed line position
// (centroid of active sensor weights), an active-sensor count and a
// line-lost flag. Each committed frame is scanned serially (8 cycles) and
// divided by repeated subtraction, then published with a one-cycle
// result_valid pulse.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   ir_bits       in   sensor frame, bit i = sensor i, 1 = line seen
//   ir_valid      in   one-cycle strobe for ir_bits
//   filtered      out  last committed frame
//   position      out  signed centroid -7..+7
//   active_cnt    out  number of set bits in the processed frame
//   line_lost     out  LOST_TIMEOUT consecutive empty results seen
//   result_valid  out  one-cycle pulse, outputs updated on the same edge
//   busy          out  FSM not idle
// ---------------------------------------------------------------------------
module ir_line_tracker
    import ir_pkg::*;
#(
    parameter int FILTER_DEPTH = 3,
    parameter int LOST_TIMEOUT = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SENSOR_COUNT-1:0] ir_bits,
    input  logic                    ir_valid,
    output logic [SENSOR_COUNT-1:0] filtered,
    output logic signed [POS_W-1:0] position,
    output logic [CNT_W-1:0]        active_cnt,
    output logic                    line_lost,
    output logic                    result_valid,
    output logic                    busy
);

    localparam logic [7:0] LOST_LIM = 8'(LOST_TIMEOUT);

    // ---------------- debounce front end ----------------
    logic                    commit;
    logic [SENSOR_COUNT-1:0] commit_frame;

    ir_debounce #(
        .FILTER_DEPTH (FILTER_DEPTH)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .bits_i   (ir_bits),
        .valid_i  (ir_valid),
        .commit_o (commit),
        .frame_o  (commit_frame)
    );

    // ---------------- control state ----------------
    ir_state_e               state_q;
    logic                    pending_q;
    logic                    busy_q;
    logic [SENSOR_COUNT-1:0] filtered_q;
    logic signed [POS_W-1:0] position_q;
    logic [CNT_W-1:0]        active_cnt_q;
    logic                    line_lost_q;
    logic                    result_valid_q;
    logic [7:0]              empty_q;

    // ---------------- datapath state ----------------
    logic [SENSOR_COUNT-1:0] scan_q;
    logic [2:0]              idx_q;
    logic signed [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [SUM_W-1:0]        rem_q;
    logic [QUO_W-1:0]        quo_q;
    logic                    neg_q;

    // ---------------- combinational helpers ----------------
    logic                    bit_on;
    logic signed [SUM_W-1:0] sum_d;
    logic [CNT_W-1:0]        cnt_d;
    logic signed [SUM_W-1:0] sum_abs_d;
    logic                    restart;
    logic [SENSOR_COUNT-1:0] start_frame;
    logic signed [POS_W-1:0] quo_s;
    logic [7:0]              empty_d;

    always_comb begin
        bit_on    = scan_q[idx_q];
        sum_d     = sum_q + (bit_on ? sensor_weight(idx_q) : '0);
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, bit_on};
        sum_abs_d = sum_d[SUM_W-1] ? -sum_d : sum_d;
        // A commit landing in the DONE cycle is folded into the restart so it
        // is not lost when the FSM would otherwise drop back to IDLE.
        restart     = pending_q || commit;
        start_frame = commit ? commit_frame : filtered_q;
        quo_s       = signed'({1'b0, quo_q});
        empty_d     = (empty_q >= LOST_LIM) ? LOST_LIM : empty_q + 8'd1;
    end

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            busy_q         <= 1'b0;
            filtered_q     <= '0;
            position_q     <= '0;
            active_cnt_q   <= '0;
            line_lost_q    <= 1'b0;
            result_valid_q <= 1'b0;
            empty_q        <= '0;
        end else begin
            result_valid_q <= 1'b0;

            // filtered tracks every commit, even while a frame is in flight.
            if (commit) begin
                filtered_q <= commit_frame;
            end

            case (state_q)
                ST_IDLE: begin
                    if (commit) begin
                        state_q <= ST_SCAN;
                        busy_q  <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (commit) begin
                        pending_q <= 1'b1;
                    end
                    if (idx_q == 3'd7) begin
                        state_q <= (cnt_d != '0) ? ST_DIV : ST_DONE;
                    end
                end

                ST_DIV: begin
                    if (commit) begin
                        pending_q <= 1'b1;
                    end
                    if (rem_q < {{(SUM_W-CNT_W){1'b0}}, cnt_q}) begin
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    result_valid_q <= 1'b1;
                    active_cnt_q   <= cnt_q;
                    if (cnt_q != '0) begin
                        position_q  <= neg_q ? -quo_s : quo_s;
                        empty_q     <= '0;
                        line_lost_q <= 1'b0;
                    end else begin
                        // Empty frame: position holds its last valid value.
                        empty_q     <= empty_d;
                        line_lost_q <= (empty_d == LOST_LIM);
                    end
                    pending_q <= 1'b0;
                    if (restart) begin
                        state_q <= ST_SCAN;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- scan / divide datapath ----------------
    // Datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    scan_q <= commit_frame;
                    sum_q  <= '0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                end
            end

            ST_SCAN: begin
                sum_q <= sum_d;
                cnt_q <= cnt_d;
                idx_q <= idx_q + 3'd1;
                // Load the divider from the final sum in the same edge that
                // consumes sensor 7, so DIV starts on the very next cycle.
                if (idx_q == 3'd7) begin
                    rem_q <= sum_abs_d;
                    quo_q <= '0;
                    neg_q <= sum_d[SUM_W-1];
                end
            end

            ST_DIV: begin
                if (rem_q >= {{(SUM_W-CNT_W){1'b0}}, cnt_q}) begin
                    rem_q <= rem_q - {{(SUM_W-CNT_W){1'b0}}, cnt_q};
                    quo_q <= quo_q + {{(QUO_W-1){1'b0}}, 1'b1};
                end
            end

            ST_DONE: begin
                if (restart) begin
                    scan_q <= start_frame;
                    sum_q  <= '0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                end
            end

            default: begin
            end
        endcase
    end

    assign filtered     = filtered_q;
    assign position     = position_q;
    assign active_cnt   = active_cnt_q;
    assign line_lost    = line_lost_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule
